// File: rtl/result_sel_pipe.sv
// result_sel_pipe: registered N_IN-way result selector with a two-entry
// skid buffer on a valid/ready interface. Both in_ready and out_* come
// straight from flops, so neither side sees a combinational path.
// Optional feature: define RESULT_SEL_PARITY_EN to add out_par, the even
// parity of out_data, which is stored with each entry.
module result_sel_pipe #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 8,
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   data_in,
    input  logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err
`ifdef RESULT_SEL_PARITY_EN
    ,
    output logic                    out_par
`endif
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
    logic               main_err_q, main_err_d, skid_err_q, skid_err_d;
`ifdef RESULT_SEL_PARITY_EN
    logic               main_par_q, main_par_d, skid_par_q, skid_par_d;
    logic               new_par;
`endif

    logic [WIDTH-1:0]   new_data;
    logic               new_err;
    logic               accept, drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = (state_q != ST_EMPTY) & out_ready;

    // Resolve the selection; out-of-range codes yield zero data and an error flag.
    always_comb begin
        new_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) new_data = data_in[k*WIDTH +: WIDTH];
        end
        new_err = (32'(sel) >= 32'(N_IN));
`ifdef RESULT_SEL_PARITY_EN
        new_par = ^new_data;
`endif
    end

    // State and ready register; reset empties both entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next state: occupancy follows accept/drain; FULL can only drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !drain)      state_d = ST_FULL;
                else if (!accept && drain) state_d = ST_EMPTY;
            end
            ST_FULL:  if (drain) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    // Entry storage: main feeds the outputs, skid catches the overflow entry.
    always_comb begin
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;
`ifdef RESULT_SEL_PARITY_EN
        main_par_d  = main_par_q;
        skid_par_d  = skid_par_q;
`endif
        if (state_q == ST_FULL && drain) begin
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
            main_err_d  = skid_err_q;
`ifdef RESULT_SEL_PARITY_EN
            main_par_d  = skid_par_q;
`endif
        end else if (accept && (state_q == ST_EMPTY || drain)) begin
            main_data_d = new_data;
            main_sel_d  = sel;
            main_err_d  = new_err;
`ifdef RESULT_SEL_PARITY_EN
            main_par_d  = new_par;
`endif
        end else if (accept) begin
            skid_data_d = new_data;
            skid_sel_d  = sel;
            skid_err_d  = new_err;
`ifdef RESULT_SEL_PARITY_EN
            skid_par_d  = new_par;
`endif
        end
    end

    // Entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
`ifdef RESULT_SEL_PARITY_EN
            main_par_q  <= 1'b0;
            skid_par_q  <= 1'b0;
`endif
        end else begin
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
`ifdef RESULT_SEL_PARITY_EN
            main_par_q  <= main_par_d;
            skid_par_q  <= skid_par_d;
`endif
        end
    end

    // Outputs come directly from registered state.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = in_ready_q;
        out_data  = main_data_q;
        out_sel   = main_sel_q;
        out_err   = main_err_q;
`ifdef RESULT_SEL_PARITY_EN
        out_par   = main_par_q;
`endif
    end

endmodule

// File: tb/tb_result_sel_pipe.sv
// Bench for result_sel_pipe: directed vector table, reset and out-of-range
// sequences, then randomized traffic against a queue-based reference.
module tb_result_sel_pipe;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int N5 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, out_valid, out_ready, out_err;
    logic [N*W-1:0]   data_in;
    logic [2:0]       sel, out_sel;
    logic [W-1:0]     out_data;

    logic             in_valid5, in_ready5, out_valid5, out_ready5, out_err5;
    logic [N5*W-1:0]  data_in5;
    logic [2:0]       sel5, out_sel5;
    logic [W-1:0]     out_data5;
`ifdef RESULT_SEL_PARITY_EN
    logic             out_par, out_par5;
`endif

    result_sel_pipe #(.WIDTH(W), .N_IN(N)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .out_err(out_err)
`ifdef RESULT_SEL_PARITY_EN
        , .out_par(out_par)
`endif
    );

    result_sel_pipe #(.WIDTH(W), .N_IN(N5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
        .data_in(data_in5), .sel(sel5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_data(out_data5), .out_sel(out_sel5), .out_err(out_err5)
`ifdef RESULT_SEL_PARITY_EN
        , .out_par(out_par5)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the block is a FIFO of at most two selected entries.
    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   sel;
        logic         err;
    } ent_t;
    ent_t q[$];

    task automatic check_model(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(q.size() < 2));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check({tag, "_out_data"}, 64'(out_data), 64'(q[0].data));
            check({tag, "_out_sel"}, 64'(out_sel), 64'(q[0].sel));
            check({tag, "_out_err"}, 64'(out_err), 64'(q[0].err));
`ifdef RESULT_SEL_PARITY_EN
            check({tag, "_out_par"}, 64'(out_par), 64'(^q[0].data));
`endif
        end
    endtask

    // One clock on the main DUT with the reference updated alongside.
    task automatic model_cycle();
        bit   acc, drn;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        drn = out_ready && (q.size() > 0);
        e.sel  = sel;
        e.err  = (int'(sel) >= N);
        e.data = e.err ? '0 : data_in[int'(sel)*W +: W];
        @(posedge clk);
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
        #1;
    endtask

    typedef struct {
        logic       iv;
        logic [2:0] sel;
        logic       ordy;
        logic       ev;
        logic [W-1:0] edata;
        logic [2:0] esel;
        logic       erdy;
    } vec_t;

    vec_t tv[15];

    function automatic vec_t mk(input logic iv, input logic [2:0] s, input logic ordy,
                                input logic ev, input logic [2:0] es, input logic erdy);
        vec_t v;
        v.iv = iv; v.sel = s; v.ordy = ordy;
        v.ev = ev; v.esel = es; v.erdy = erdy;
        v.edata = 32'h1000_0000 + 32'(es);
        return v;
    endfunction

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] edata;
        logic         eerr;
    } vec5_t;

    vec5_t tv5[4];

    initial begin
        // Directed vectors: inputs for one cycle, outputs expected after that edge.
        tv[0] = mk(1, 5, 1, 1, 5, 1);
        for (int k = 0; k < 8; k++) tv[1+k] = mk(1, 3'(k), 1, 1, 3'(k), 1);
        tv[9]  = mk(0, 0, 1, 0, 0, 1);
        tv[10] = mk(1, 1, 0, 1, 1, 1);
        tv[11] = mk(1, 2, 0, 1, 1, 0);
        tv[12] = mk(1, 3, 0, 1, 1, 0);
        tv[13] = mk(0, 0, 1, 1, 2, 1);
        tv[14] = mk(0, 0, 1, 0, 0, 1);

        tv5[0] = '{sel: 3'd6, edata: 32'h0,         eerr: 1'b1};
        tv5[1] = '{sel: 3'd4, edata: 32'h5000_0004, eerr: 1'b0};
        tv5[2] = '{sel: 3'd5, edata: 32'h0,         eerr: 1'b1};
        tv5[3] = '{sel: 3'd0, edata: 32'h5000_0000, eerr: 1'b0};

        rst = 1'b1;
        in_valid = 1'b1; sel = 3'd5; out_ready = 1'b1;
        in_valid5 = 1'b0; sel5 = 3'd0; out_ready5 = 1'b1;
        for (int k = 0; k < N; k++)  data_in[k*W +: W]  = 32'h1000_0000 + 32'(k);
        for (int k = 0; k < N5; k++) data_in5[k*W +: W] = 32'h5000_0000 + 32'(k);

        // Held in reset across edges with in_valid high: nothing accepted.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_sel", 64'(out_sel), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef RESULT_SEL_PARITY_EN
        check("rst_out_par", 64'(out_par), 64'(0));
`endif
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            in_valid = tv[i].iv; sel = tv[i].sel; out_ready = tv[i].ordy;
            @(posedge clk); #1;
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tv[i].erdy));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tv[i].ev));
            if (tv[i].ev) begin
                check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(tv[i].edata));
                check($sformatf("vec%0d_out_sel", i), 64'(out_sel), 64'(tv[i].esel));
                check($sformatf("vec%0d_out_err", i), 64'(out_err), 64'(0));
            end
        end

        // Out-of-range selects on a five-input instance.
        in_valid5 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel5 = tv5[i].sel;
            @(posedge clk); #1;
            check($sformatf("n5_%0d_out_valid", i), 64'(out_valid5), 64'(1));
            check($sformatf("n5_%0d_out_data", i), 64'(out_data5), 64'(tv5[i].edata));
            check($sformatf("n5_%0d_out_sel", i), 64'(out_sel5), 64'(tv5[i].sel));
            check($sformatf("n5_%0d_out_err", i), 64'(out_err5), 64'(tv5[i].eerr));
        end
        in_valid5 = 1'b0;

        // Fill to FULL, then reset mid-cycle.
        in_valid = 1'b1; out_ready = 1'b0; sel = 3'd1;
        @(posedge clk); #1;
        sel = 3'd2;
        @(posedge clk); #1;
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_out_data", 64'(out_data), 64'h1000_0001);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_data", 64'(out_data), 64'(0));
        sel = 3'd6;
        @(posedge clk); #1;
        check("rst_hold_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; sel = 3'd4; out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", 64'(out_valid), 64'(1));
        check("release_out_data", 64'(out_data), 64'h1000_0004);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("no_stale_out_valid", 64'(out_valid), 64'(0));
        check("no_stale_in_ready", 64'(in_ready), 64'(1));

`ifdef RESULT_SEL_PARITY_EN
        data_in[2*W +: W] = 32'h0000_0007;
        data_in[3*W +: W] = 32'h0000_0003;
        in_valid = 1'b1; sel = 3'd2;
        @(posedge clk); #1;
        check("par7_out_par", 64'(out_par), 64'(1));
        sel = 3'd3;
        @(posedge clk); #1;
        check("par3_out_par", 64'(out_par), 64'(0));
        in_valid = 1'b0;
        @(posedge clk); #1;
`endif

        // Random traffic with alternating backpressure phases.
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            check_model("rand");
            for (int k = 0; k < N; k++) data_in[k*W +: W] = $urandom;
            sel       = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < (((c / 200) % 2) ? 8 : 3));
            model_cycle();
        end
        check_model("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/result_sel_pipe.md
# result_sel_pipe

Registered, parametrised result selector for the execute stage: picks one of N_IN operand/result buses by a select code and presents it downstream through a valid/ready interface. Replaces the fixed 8-input, 32-bit combinational selector with a configurable-width, configurable-fan-in block. Holds a two-entry skid buffer so the execute-stage handshake is fully registered in both directions. Sits between the functional-unit outputs and the writeback/forwarding network.

## Interface
- WIDTH, 32, data bus width in bits (>=1)
- N_IN, 8, number of selectable inputs (>=2; need not be a power of two)
- SEL_W, $clog2(N_IN), select width; derived, not overridden
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream offers data_in/sel
- in_ready  output  1  block can accept this cycle
- data_in  input  N_IN*WIDTH  packed inputs; input k at bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  select code
- out_valid  output  1  out_* hold a valid result
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  selected data
- out_sel  output  SEL_W  select code that produced out_data
- out_err  output  1  sel was >= N_IN
- out_par  output  1  present only with RESULT_SEL_PARITY_EN (see Configuration)

## Operation
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Selection: sel < N_IN -> data_in[sel]; sel >= N_IN -> data 0, err 1. Selection resolved combinationally, then registered with sel and err as one entry.
- Storage: main register (drives out_*) and skid register.
- States: EMPTY (out_valid=0), ONE (out_valid=1, skid empty), FULL (out_valid=1, skid holds entry).
- EMPTY: accept -> ONE, main loads new entry; else stay.
- ONE: accept & drain -> ONE, main loads new; accept & !drain -> FULL, skid loads new, main held; !accept & drain -> EMPTY; else stay.
- FULL: no accept possible; drain -> ONE, main <= skid; else stay.
- in_ready = (state != FULL), registered; never combinationally dependent on out_ready or in_valid.
- Ordering: strict FIFO; entries never dropped, duplicated or reordered.
- out_* stable while out_valid=1 and out_ready=0.
- data_in/sel ignored when in_valid=0 or in_ready=0.

## Timing
- Latency: entry accepted at edge t appears on out_* after edge t (same cycle available to downstream at t+1 sampling); 1 cycle minimum.
- Throughput: one entry per cycle sustained while out_ready=1.
- Stall: in_ready falls one cycle after the first unaccepted output with a new accept (ONE->FULL); rises the cycle after FULL drains.
- Reset (async assert, any state): state EMPTY, out_valid 0, out_data 0, out_sel 0, out_err 0, out_par 0, in_ready 1, skid cleared. Mid-transfer entries are discarded. No accept on any edge while rst=1.
- Deassertion: first accept possible on first rising edge with rst=0.

## Configuration
- RESULT_SEL_PARITY_EN defined: out_par port exists; equals even parity (XOR reduction) of out_data, computed before registering and stored per entry (skid included); error entries carry parity 0.
- Not defined: out_par port and its storage absent; all other behaviour identical.

## Test plan
- Reset then WIDTH=32,N_IN=8: inputs k=0x1000_0000+k, sel=5, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0x1000_0005, out_sel=5, out_err=0.
- Back-to-back sel=0..7 with out_ready=1 -> eight consecutive valid outputs in order, in_ready constant 1.
- out_ready=0, push sel=1 then sel=2 -> in_ready=0 after second accept, out_data holds input 1; raise out_ready -> input 1, then input 2, in_ready returns 1.
- N_IN=5, sel=6 -> out_data=0, out_err=1, out_sel=6.
- Fill to FULL, assert rst mid-cycle -> out_valid=0, in_ready=1 immediately; no stale entry after release.
- With RESULT_SEL_PARITY_EN, selected 0x0000_0007 -> out_par=1; 0x0000_0003 -> out_par=0.
